// File: rtl/axi4_burst_tester.sv
// AXI4 bring-up master: writes one INCR burst of seed+i, reads the same burst back and checks every beat.
// AXI valids rise two edges after start; every output is registered; each phase waits on its own handshake.
module axi4_burst_tester #(
   parameter int         ADDR_WIDTH = 32,
   parameter int         DATA_WIDTH = 32,
   parameter logic [7:0] AXI_ID     = 8'h00
) (
   input  logic                      axi_aclk,
   input  logic                      axi_resetn,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [7:0]                burst_len,
   input  logic [DATA_WIDTH-1:0]     seed,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [15:0]               err_cnt,
   output logic                      resp_err,
   output logic [7:0]                axi_awid,
   output logic [ADDR_WIDTH-1:0]     axi_awaddr,
   output logic [7:0]                axi_awlen,
   output logic [2:0]                axi_awsize,
   output logic [1:0]                axi_awburst,
   output logic                      axi_awlock,
   output logic [3:0]                axi_awcache,
   output logic [2:0]                axi_awprot,
   output logic [3:0]                axi_awqos,
   output logic [3:0]                axi_awregion,
   output logic                      axi_awvalid,
   input  logic                      axi_awready,
   output logic [DATA_WIDTH-1:0]     axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
   output logic                      axi_wlast,
   output logic                      axi_wvalid,
   input  logic                      axi_wready,
   input  logic [7:0]                axi_bid,
   input  logic [1:0]                axi_bresp,
   input  logic                      axi_bvalid,
   output logic                      axi_bready,
   output logic [7:0]                axi_arid,
   output logic [ADDR_WIDTH-1:0]     axi_araddr,
   output logic [7:0]                axi_arlen,
   output logic [2:0]                axi_arsize,
   output logic [1:0]                axi_arburst,
   output logic                      axi_arlock,
   output logic [3:0]                axi_arcache,
   output logic [2:0]                axi_arprot,
   output logic [3:0]                axi_arqos,
   output logic [3:0]                axi_arregion,
   output logic                      axi_arvalid,
   input  logic                      axi_arready,
   input  logic [7:0]                axi_rid,
   input  logic [DATA_WIDTH-1:0]     axi_rdata,
   input  logic [1:0]                axi_rresp,
   input  logic                      axi_rlast,
   input  logic                      axi_rvalid,
   output logic                      axi_rready
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int SIZE   = $clog2(STRB_W);

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD, DONE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat;
   logic [DATA_WIDTH-1:0] seed_q;
   logic                  aw_sent, w_sent;
   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                  aw_done, w_done, rd_mis;
   logic [15:0]           err_nxt;
   logic                  resp_nxt;
   logic                  unused_ok;

   assign axi_awid     = AXI_ID;
   assign axi_awaddr   = addr_q;
   assign axi_awlen    = len_q;
   assign axi_awsize   = 3'(SIZE);
   assign axi_awburst  = 2'b01;
   assign axi_awlock   = 1'b0;
   assign axi_awcache  = 4'd0;
   assign axi_awprot   = 3'd0;
   assign axi_awqos    = 4'd0;
   assign axi_awregion = 4'd0;
   assign axi_wstrb    = '1;
   assign axi_arid     = AXI_ID;
   assign axi_araddr   = addr_q;
   assign axi_arlen    = len_q;
   assign axi_arsize   = 3'(SIZE);
   assign axi_arburst  = 2'b01;
   assign axi_arlock   = 1'b0;
   assign axi_arcache  = 4'd0;
   assign axi_arprot   = 3'd0;
   assign axi_arqos    = 4'd0;
   assign axi_arregion = 4'd0;
   assign unused_ok    = ^{axi_bid, axi_rid};

   assign aw_hs = axi_awvalid & axi_awready;
   assign w_hs  = axi_wvalid & axi_wready;
   assign b_hs  = axi_bvalid & axi_bready;
   assign ar_hs = axi_arvalid & axi_arready;
   assign r_hs  = axi_rvalid & axi_rready;

   // AW and the last W beat may complete in either order, or on the same edge
   assign aw_done = aw_sent | aw_hs;
   assign w_done  = w_sent | (w_hs & axi_wlast);

   assign rd_mis   = r_hs && (axi_rdata != seed_q + DATA_WIDTH'(beat));
   assign err_nxt  = (rd_mis && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
   assign resp_nxt = resp_err
                   | (b_hs && axi_bresp != 2'b00)
                   | (r_hs && (axi_rresp != 2'b00 || axi_rlast != (beat == len_q)));

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WR;
         WR:      if (aw_done && w_done) state_nxt = WR_RESP;
         WR_RESP: if (b_hs) state_nxt = RD_ADDR;
         RD_ADDR: if (ar_hs) state_nxt = RD;
         RD:      if (r_hs && beat == len_q) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         addr_q      <= '0;
         len_q       <= '0;
         seed_q      <= '0;
         beat        <= '0;
         aw_sent     <= 1'b0;
         w_sent      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_cnt     <= '0;
         resp_err    <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_wdata   <= '0;
         axi_wlast   <= 1'b0;
         axi_bready  <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               addr_q   <= base_addr & ~ADDR_WIDTH'(STRB_W - 1);
               len_q    <= burst_len;
               seed_q   <= seed;
               beat     <= '0;
               aw_sent  <= 1'b0;
               w_sent   <= 1'b0;
               err_cnt  <= '0;
               resp_err <= 1'b0;
               pass     <= 1'b0;
            end
            WR: begin
               // busy is still low only on the first WR cycle: launch AW and W together
               if (!busy) begin
                  busy        <= 1'b1;
                  axi_awvalid <= 1'b1;
                  axi_wvalid  <= 1'b1;
                  axi_wdata   <= seed_q;
                  axi_wlast   <= (len_q == 8'd0);
               end
               if (aw_hs) begin
                  axi_awvalid <= 1'b0;
                  aw_sent     <= 1'b1;
               end
               if (w_hs) begin
                  if (axi_wlast) begin
                     axi_wvalid <= 1'b0;
                     axi_wlast  <= 1'b0;
                     w_sent     <= 1'b1;
                  end else begin
                     axi_wdata <= axi_wdata + DATA_WIDTH'(1);
                     beat      <= beat + 8'd1;
                     axi_wlast <= (beat + 8'd1 == len_q);
                  end
               end
               if (aw_done && w_done) axi_bready <= 1'b1;
            end
            WR_RESP: if (b_hs) begin
               axi_bready  <= 1'b0;
               axi_arvalid <= 1'b1;
               resp_err    <= resp_nxt;
            end
            RD_ADDR: if (ar_hs) begin
               axi_arvalid <= 1'b0;
               axi_rready  <= 1'b1;
               beat        <= '0;
            end
            RD: if (r_hs) begin
               beat     <= beat + 8'd1;
               err_cnt  <= err_nxt;
               resp_err <= resp_nxt;
               if (beat == len_q) begin
                  axi_rready <= 1'b0;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  pass       <= (err_nxt == 16'd0) && !resp_nxt;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_burst_tester.sv
// Directed bench for axi4_burst_tester: behavioural AXI4 RAM slave with stall, gating and fault-injection modes.
module tb_axi4_burst_tester;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start;
   logic [31:0] base_addr, seed;
   logic [7:0]  burst_len;
   logic        busy, done, pass, resp_err;
   logic [15:0] err_cnt;
   logic [7:0]  awid, awlen, arid, arlen, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [2:0]  awsize, awprot, arsize, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awlock, arlock;
   logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion, wstrb;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   axi4_burst_tester dut (
      .axi_aclk(clk), .axi_resetn(rst_n), .start(start), .base_addr(base_addr),
      .burst_len(burst_len), .seed(seed), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .resp_err(resp_err),
      .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
      .axi_awburst(awburst), .axi_awlock(awlock), .axi_awcache(awcache), .axi_awprot(awprot),
      .axi_awqos(awqos), .axi_awregion(awregion), .axi_awvalid(awvalid), .axi_awready(awready),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
      .axi_wready(wready), .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
      .axi_bready(bready), .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
      .axi_arsize(arsize), .axi_arburst(arburst), .axi_arlock(arlock), .axi_arcache(arcache),
      .axi_arprot(arprot), .axi_arqos(arqos), .axi_arregion(arregion), .axi_arvalid(arvalid),
      .axi_arready(arready), .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp),
      .axi_rlast(rlast), .axi_rvalid(rvalid), .axi_rready(rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave modes and state
   bit          stall, aw_wait_w, corrupt, bad_rlast;
   logic [1:0]  bresp_mode;
   logic [31:0] mem [0:255];
   bit          aw_got, b_sent, b_taken, ar_got, r_taken;
   logic [31:0] aw_addr_s, ar_addr_s;
   logic [7:0]  aw_len_s, ar_len_s;
   int          r_beat, wcyc, done_cnt;
   logic [31:0] wq_data[$];
   bit          wq_last[$];
   bit          pend_aw, pend_w, pend_ar, done_prev, wlast_prev;
   logic [31:0] wdata_prev;

   function automatic logic rnd();
      return stall ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   // Handshakes are observed at posedge; slave outputs change only at negedge.
   initial begin : slave
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            aw_got = 0; b_sent = 0; b_taken = 0; ar_got = 0; r_taken = 0; r_beat = 0;
            pend_aw = 0; pend_w = 0; pend_ar = 0;
         end else begin
            pend_aw    = awvalid && !awready;
            pend_w     = wvalid && !wready;
            pend_ar    = arvalid && !arready;
            wdata_prev = wdata;
            wlast_prev = wlast;
            if (wvalid) wcyc++;
            if (awvalid && awready) begin aw_got = 1; aw_addr_s = awaddr; aw_len_s = awlen; end
            if (wvalid && wready) begin wq_data.push_back(wdata); wq_last.push_back(wlast); end
            if (bvalid && bready) b_taken = 1;
            if (arvalid && arready) begin ar_got = 1; ar_addr_s = araddr; ar_len_s = arlen; r_beat = 0; end
            if (rvalid && rready) begin
               r_taken = 1;
               r_beat++;
               if (r_beat > ar_len_s) ar_got = 0;
            end
         end
         @(negedge clk);
         if (rst_n) begin
            if (pend_aw) check_eq("aw_hold", awvalid, 1'b1);
            if (pend_w)  check_eq("w_hold", {wvalid, wlast, wdata}, {1'b1, wlast_prev, wdata_prev});
            if (pend_ar) check_eq("ar_hold", arvalid, 1'b1);
            if (done) begin
               done_cnt++;
               check_eq("done_pulse", {done_prev, busy}, 2'b00);
            end
         end
         done_prev = done;
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
         end else begin
            awready = aw_wait_w ? (wvalid && rnd()) : rnd();
            wready  = rnd();
            arready = rnd();
            if (b_taken) begin bvalid = 0; b_taken = 0; end
            if (aw_got && !b_sent && wq_data.size() == aw_len_s + 1) begin
               for (int k = 0; k < wq_data.size(); k++) mem[8'((aw_addr_s >> 2) + k)] = wq_data[k];
               bvalid = 1; bresp = bresp_mode; b_sent = 1;
            end
            if (r_taken) begin rvalid = 0; r_taken = 0; end
            if (ar_got && !rvalid && rnd()) begin
               rdata = mem[8'((ar_addr_s >> 2) + r_beat)];
               if (corrupt && r_beat == 3) rdata = rdata ^ 32'h1;
               rlast  = bad_rlast ? (r_beat == 0 || r_beat == ar_len_s) : (r_beat == ar_len_s);
               rresp  = 2'b00;
               rvalid = 1;
            end
         end
      end
   end

   task automatic launch(input logic [31:0] b, input logic [7:0] l, input logic [31:0] s);
      #1;
      wq_data.delete(); wq_last.delete();
      aw_got = 0; b_sent = 0; ar_got = 0; wcyc = 0; done_cnt = 0;
      @(negedge clk);
      base_addr = b; burst_len = l; seed = s; start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      check_eq("launch", {busy, awvalid, wvalid}, 3'b111);
   endtask

   task automatic run_test(input logic [31:0] b, input logic [7:0] l, input logic [31:0] s,
                           input bit exp_pass, input logic [15:0] exp_err, input bit exp_resp,
                           input bit restart);
      bit seen = 0;
      launch(b, l, s);
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
         start = restart && (i == 3);
      end
      start = 0;
      check_eq("done_seen", seen, 1'b1);
      check_eq("pass", pass, exp_pass);
      check_eq("err_cnt", err_cnt, exp_err);
      check_eq("resp_err", resp_err, exp_resp);
      check_eq("w_beats", wq_data.size(), l + 1);
      for (int i = 0; i < wq_data.size(); i++) begin
         check_eq("w_data", wq_data[i], 32'(s + i));
         check_eq("w_last", wq_last[i], i == l);
      end
      repeat (10) @(negedge clk);
      check_eq("done_count", done_cnt, 1);
      check_eq("idle_hold", {busy, pass}, {1'b0, exp_pass});
   endtask

   initial begin
      bit hit;
      start = 0; base_addr = 0; burst_len = 0; seed = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
      stall = 0; aw_wait_w = 0; corrupt = 0; bad_rlast = 0; bresp_mode = 2'b00;
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", {busy, done, pass, resp_err, err_cnt, awvalid, wvalid, wlast, bready, arvalid, rready}, 0);
      check_eq("rst_addr", {awaddr, araddr, wdata}, 0);
      check_eq("const_fields", {awsize, awburst, wstrb, arsize, arburst, awid}, {3'd2, 2'b01, 4'hF, 3'd2, 2'b01, 8'h00});
      rst_n = 1;
      @(negedge clk);

      run_test(32'h100, 8'd15, 32'hA5A50000, 1, 0, 0, 0);
      check_eq("w_cycles", wcyc, 16);
      check_eq("t1_last", {wq_data[15], wq_last[14]}, {32'hA5A5000F, 1'b0});

      run_test(32'h200, 8'd0, 32'h12345678, 1, 0, 0, 0);
      check_eq("t2_single", {wq_data[0], wq_last[0]}, {32'h12345678, 1'b1});

      run_test(32'h300, 8'd3, 32'hFFFFFFFE, 1, 0, 0, 0);
      check_eq("wrap_b2", wq_data[2], 32'h00000000);
      check_eq("wrap_b3", wq_data[3], 32'h00000001);

      corrupt = 1; bresp_mode = 2'b10;
      run_test(32'h400, 8'd7, 32'h11110000, 0, 16'd1, 1, 0);
      corrupt = 0; bresp_mode = 2'b00;

      bad_rlast = 1;
      run_test(32'h500, 8'd3, 32'h22220000, 0, 16'd0, 1, 0);
      bad_rlast = 0;

      stall = 1;
      run_test(32'h140, 8'd15, 32'hDEAD0000, 1, 0, 0, 0);
      run_test(32'h183, 8'd31, 32'h5A5A5A5A, 1, 0, 0, 0);
      stall = 0;

      aw_wait_w = 1;
      run_test(32'h600, 8'd7, 32'h33330000, 1, 0, 0, 1);
      aw_wait_w = 0;

      // reset in the middle of W beat 5
      launch(32'h100, 8'd15, 32'hC0DE0000);
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (wq_data.size() == 4) hit = 1;
      end
      check_eq("reach_beat5", {hit, wvalid}, 2'b11);
      #1 rst_n = 0;
      #1;
      check_eq("mid_rst_ctrl", {busy, done, pass, resp_err, err_cnt, awvalid, wvalid, wlast, bready, arvalid, rready}, 0);
      check_eq("mid_rst_data", {awaddr, wdata, awlen}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      run_test(32'h100, 8'd5, 32'h0BADF00D, 1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
